sim_ram_req_adapter: RTL and testbench
======================================

SIM_RAM_REQ_ADAPTER -- requirements
Module: sim_ram_req_adapter

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 12, meaning RAM word-address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 32, meaning data width in bits; must be a multiple of 8.
REQ-003 SHALL have parameter READ_DELAY, default 1, meaning RAM read latency in cycles; must be >= 1.
REQ-004 SHALL have parameter WRITE_DELAY, default 1, meaning RAM write-commit latency in cycles; must be >= 1.
REQ-005 SHALL have parameter FIFO_DEPTH, default 4, meaning response FIFO entries; must be >= 1.
REQ-006 SHALL use one clock and an asynchronous, active-low reset.
REQ-007 SHALL have port clock, input, 1 bit, the single clock; all state changes on the rising edge.
REQ-008 SHALL have port reset, input, 1 bit, asynchronous active-low reset.
REQ-009 SHALL have port req_valid, input, 1 bit, upstream request valid.
REQ-010 SHALL have port req_ready, output, 1 bit, request accepted when high with req_valid.
REQ-011 SHALL have port req_write, input, 1 bit, 1 for write, 0 for read.
REQ-012 SHALL have port req_addr, input, ADDR_WIDTH+2 bits, byte address; bits [1:0] are ignored.
REQ-013 SHALL have port req_wstrb, input, DATA_WIDTH/8 bits, write byte strobes.
REQ-014 SHALL have port req_wdata, input, DATA_WIDTH bits, write data.
REQ-015 SHALL have port resp_valid, output, 1 bit, response valid.
REQ-016 SHALL have port resp_ready, input, 1 bit, downstream accepts response.
REQ-017 SHALL have port resp_write, output, 1 bit, response belongs to a write.
REQ-018 SHALL have port resp_rdata, output, DATA_WIDTH bits, read data; 0 for write responses.
REQ-019 SHALL have ports ram_raddr (output, ADDR_WIDTH), ram_waddr (output, ADDR_WIDTH), ram_wstrb (output, DATA_WIDTH/8) and ram_wdata (output, DATA_WIDTH), the RAM request side.
REQ-020 SHALL have port ram_rdata, input, DATA_WIDTH bits, the RAM read data.

Function
REQ-021 SHALL accept a request (fire) in a cycle where req_valid and req_ready are both high.
REQ-022 SHALL drive ram_raddr = req_addr[ADDR_WIDTH+1:2] combinationally at all times.
REQ-023 SHALL drive ram_waddr, ram_wdata and ram_wstrb combinationally from the request in a write fire cycle.
REQ-024 SHALL hold ram_wstrb at 0 in every non-write-fire cycle, so no spurious RAM writes occur.
REQ-025 SHALL give every fire an entry in a tag pipeline of LAT = max(READ_DELAY, WRITE_DELAY) stages, each stage holding {valid, write, data}.
REQ-026 SHALL, for a read, capture ram_rdata into the entry's data field when the entry reaches stage READ_DELAY (READ_DELAY edges after fire).
REQ-027 SHALL push each entry into the response FIFO on leaving stage LAT, so total latency from fire to earliest resp_valid is LAT+1 cycles.
REQ-028 SHALL return responses strictly in acceptance order.
REQ-029 SHALL maintain credits = pipeline occupancy + FIFO count, which never exceeds FIFO_DEPTH.
REQ-030 SHALL set req_ready = (credits < FIFO_DEPTH, or a FIFO pop this cycle) AND (req_write OR wr_inflight == 0).
REQ-031 SHALL keep wr_inflight counting writes fired but not yet past WRITE_DELAY stages; reads therefore stall until earlier writes commit (no RAW hazard).
REQ-032 SHALL never stall the pipeline; backpressure applies only at req_ready.
REQ-033 SHALL allow a push and a pop in the same cycle when the FIFO is full.
REQ-034 SHALL use wrapping FIFO read and write pointers modulo FIFO_DEPTH.
REQ-035 SHALL keep resp_valid = FIFO not empty and keep the FIFO head stable while resp_valid && !resp_ready.
REQ-036 SHALL drop and never recover requests whose pipeline entries are in flight when reset asserts.

Reset
REQ-037 SHALL, on reset asserted, immediately clear all pipeline valid bits, FIFO pointers, credits and wr_inflight.
REQ-038 SHALL drive resp_valid = 0, resp_write = 0, resp_rdata = 0 and ram_wstrb = 0 while reset is asserted.
REQ-039 SHALL deassert req_ready while reset is low, and assert it in the first cycle after reset is released.

Verification
REQ-040 SHALL be verified by: write addr 0x10, wstrb 0xF, data 0xDEADBEEF, then read 0x10 -> read fires only after the write commits; resp_rdata = 0xDEADBEEF.
REQ-041 SHALL be verified by: wstrb 0x3, data 0x1234_5678 over word 0xFFFFFFFF -> subsequent read returns 0xFFFF5678.
REQ-042 SHALL be verified by: resp_ready = 0 with 6 reads issued (FIFO_DEPTH = 4) -> exactly 4 fire, req_ready = 0, and all 4 drain in order once resp_ready = 1.
REQ-043 SHALL be verified by: READ_DELAY = 3, WRITE_DELAY = 1, mixed W,R,W back-to-back -> responses arrive in order W,R,W, first resp_valid 4 cycles after fire.
REQ-044 SHALL be verified by: FIFO full with simultaneous pop and new fire -> count stays 4, no loss, and pointers wrap correctly over 10 transactions.
REQ-045 SHALL be verified by: reset pulsed low with 2 entries in flight -> resp_valid = 0 immediately, no stale response after release, and ram_wstrb = 0 during reset.

Source files
------------

// File: rtl/sim_ram_req_adapter.sv
// Valid/ready request adapter in front of a fixed-latency simulation RAM.
// Each fire is tagged through a LAT-stage pipeline and returned in order via a credit-guarded FIFO.
module sim_ram_req_adapter #(
   parameter int ADDR_WIDTH  = 12,
   parameter int DATA_WIDTH  = 32,
   parameter int READ_DELAY  = 1,
   parameter int WRITE_DELAY = 1,
   parameter int FIFO_DEPTH  = 4
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic                    req_valid,
   output logic                    req_ready,
   input  logic                    req_write,
   input  logic [ADDR_WIDTH+1:0]   req_addr,
   input  logic [DATA_WIDTH/8-1:0] req_wstrb,
   input  logic [DATA_WIDTH-1:0]   req_wdata,
   output logic                    resp_valid,
   input  logic                    resp_ready,
   output logic                    resp_write,
   output logic [DATA_WIDTH-1:0]   resp_rdata,
   output logic [ADDR_WIDTH-1:0]   ram_raddr,
   output logic [ADDR_WIDTH-1:0]   ram_waddr,
   output logic [DATA_WIDTH/8-1:0] ram_wstrb,
   output logic [DATA_WIDTH-1:0]   ram_wdata,
   input  logic [DATA_WIDTH-1:0]   ram_rdata
);

   localparam int LAT = (READ_DELAY > WRITE_DELAY) ? READ_DELAY : WRITE_DELAY;
   localparam int PW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CW  = $clog2(FIFO_DEPTH + 1);
   localparam int WW  = $clog2(WRITE_DELAY + 1);

   logic                  fire;
   logic                  wr_fire;
   logic                  wr_leave;
   logic                  pop;
   logic                  push;
   logic                  has_credit;
   logic                  no_hazard;
   logic [LAT-1:0]        pipe_valid;
   logic [LAT-1:0]        pipe_write;
   logic [DATA_WIDTH-1:0] pipe_data [LAT];
   logic [DATA_WIDTH-1:0] stage_out [LAT];
   logic [CW-1:0]         credits;
   logic [CW-1:0]         fifo_count;
   logic [WW-1:0]         wr_inflight;
   logic [PW-1:0]         wr_ptr;
   logic [PW-1:0]         rd_ptr;
   logic                  fifo_write [FIFO_DEPTH];
   logic [DATA_WIDTH-1:0] fifo_data [FIFO_DEPTH];
   logic [1:0]            unused_addr_bits;

   function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] ptr);
      return (ptr == PW'(FIFO_DEPTH - 1)) ? '0 : ptr + PW'(1);
   endfunction

   assign unused_addr_bits = req_addr[1:0];

   // Credits cover both the pipeline and the FIFO, so a pop frees a slot for a same-cycle fire.
   assign pop        = resp_valid & resp_ready;
   assign has_credit = (credits < CW'(FIFO_DEPTH)) | pop;
   assign no_hazard  = req_write | (wr_inflight == '0);
   assign req_ready  = reset & has_credit & no_hazard;
   assign fire       = req_valid & req_ready;
   assign wr_fire    = fire & req_write;
   assign wr_leave   = pipe_valid[WRITE_DELAY-1] & pipe_write[WRITE_DELAY-1];
   assign push       = pipe_valid[LAT-1];

   assign ram_raddr = req_addr[ADDR_WIDTH+1:2];
   assign ram_waddr = req_addr[ADDR_WIDTH+1:2];
   assign ram_wdata = req_wdata;
   assign ram_wstrb = wr_fire ? req_wstrb : '0;

   assign resp_valid = (fifo_count != '0);
   assign resp_write = resp_valid & fifo_write[rd_ptr];
   assign resp_rdata = resp_valid ? fifo_data[rd_ptr] : '0;

   // Read data is sampled while a read sits in stage READ_DELAY, as it moves on.
   always_comb begin
      for (int k = 0; k < LAT; k++) begin
         if ((k == READ_DELAY - 1) && pipe_valid[k] && !pipe_write[k]) begin
            stage_out[k] = ram_rdata;
         end else begin
            stage_out[k] = pipe_data[k];
         end
      end
   end

   // Tag pipeline: never stalls, entries simply shift one stage per cycle.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         pipe_valid <= '0;
         pipe_write <= '0;
         for (int k = 0; k < LAT; k++) begin
            pipe_data[k] <= '0;
         end
      end else begin
         pipe_valid[0] <= fire;
         pipe_write[0] <= wr_fire;
         pipe_data[0]  <= '0;
         for (int k = 1; k < LAT; k++) begin
            pipe_valid[k] <= pipe_valid[k-1];
            pipe_write[k] <= pipe_write[k-1];
            pipe_data[k]  <= stage_out[k-1];
         end
      end
   end

   // Credit and write-in-flight accounting.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         credits     <= '0;
         wr_inflight <= '0;
      end else begin
         case ({fire, pop})
            2'b10:   credits <= credits + CW'(1);
            2'b01:   credits <= credits - CW'(1);
            default: credits <= credits;
         endcase
         case ({wr_fire, wr_leave})
            2'b10:   wr_inflight <= wr_inflight + WW'(1);
            2'b01:   wr_inflight <= wr_inflight - WW'(1);
            default: wr_inflight <= wr_inflight;
         endcase
      end
   end

   // Response FIFO with wrapping pointers; push and pop may coincide.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
         for (int k = 0; k < FIFO_DEPTH; k++) begin
            fifo_write[k] <= 1'b0;
            fifo_data[k]  <= '0;
         end
      end else begin
         if (push) begin
            fifo_write[wr_ptr] <= pipe_write[LAT-1];
            fifo_data[wr_ptr]  <= stage_out[LAT-1];
            wr_ptr             <= ptr_next(wr_ptr);
         end
         if (pop) begin
            rd_ptr <= ptr_next(rd_ptr);
         end
         case ({push, pop})
            2'b10:   fifo_count <= fifo_count + CW'(1);
            2'b01:   fifo_count <= fifo_count - CW'(1);
            default: fifo_count <= fifo_count;
         endcase
      end
   end

endmodule

// File: tb/tb_sim_ram_req_adapter.sv
// Directed bench for sim_ram_req_adapter: a default instance and a READ_DELAY=3 instance,
// each in front of a small behavioural RAM whose words start as 0x5A000000 + word index.
module tb_sim_ram_req_adapter;

   logic clock = 1'b0;
   logic reset;
   always #5 clock = ~clock;

   logic        a_req_valid, a_req_ready, a_req_write;
   logic [13:0] a_req_addr;
   logic [3:0]  a_req_wstrb;
   logic [31:0] a_req_wdata;
   logic        a_resp_valid, a_resp_ready, a_resp_write;
   logic [31:0] a_resp_rdata;
   logic [11:0] a_ram_raddr, a_ram_waddr;
   logic [3:0]  a_ram_wstrb;
   logic [31:0] a_ram_wdata, a_ram_rdata;

   logic        b_req_valid, b_req_ready, b_req_write;
   logic [13:0] b_req_addr;
   logic [3:0]  b_req_wstrb;
   logic [31:0] b_req_wdata;
   logic        b_resp_valid, b_resp_ready, b_resp_write;
   logic [31:0] b_resp_rdata;
   logic [11:0] b_ram_raddr, b_ram_waddr;
   logic [3:0]  b_ram_wstrb;
   logic [31:0] b_ram_wdata, b_ram_rdata;

   sim_ram_req_adapter dut_a (
      .clock(clock), .reset(reset),
      .req_valid(a_req_valid), .req_ready(a_req_ready), .req_write(a_req_write),
      .req_addr(a_req_addr), .req_wstrb(a_req_wstrb), .req_wdata(a_req_wdata),
      .resp_valid(a_resp_valid), .resp_ready(a_resp_ready), .resp_write(a_resp_write),
      .resp_rdata(a_resp_rdata), .ram_raddr(a_ram_raddr), .ram_waddr(a_ram_waddr),
      .ram_wstrb(a_ram_wstrb), .ram_wdata(a_ram_wdata), .ram_rdata(a_ram_rdata)
   );

   sim_ram_req_adapter #(.READ_DELAY(3), .WRITE_DELAY(1)) dut_b (
      .clock(clock), .reset(reset),
      .req_valid(b_req_valid), .req_ready(b_req_ready), .req_write(b_req_write),
      .req_addr(b_req_addr), .req_wstrb(b_req_wstrb), .req_wdata(b_req_wdata),
      .resp_valid(b_resp_valid), .resp_ready(b_resp_ready), .resp_write(b_resp_write),
      .resp_rdata(b_resp_rdata), .ram_raddr(b_ram_raddr), .ram_waddr(b_ram_waddr),
      .ram_wstrb(b_ram_wstrb), .ram_wdata(b_ram_wdata), .ram_rdata(b_ram_rdata)
   );

   // Behavioural RAMs: writes commit at the fire edge, reads return after 1 or 3 cycles.
   logic [31:0] mem_a [4096];
   logic [31:0] mem_b [4096];
   logic [31:0] rp_a;
   logic [31:0] rp_b [3];
   assign a_ram_rdata = rp_a;
   assign b_ram_rdata = rp_b[2];

   always @(posedge clock) begin
      rp_a    <= mem_a[a_ram_raddr];
      rp_b[0] <= mem_b[b_ram_raddr];
      rp_b[1] <= rp_b[0];
      rp_b[2] <= rp_b[1];
      if (!reset) begin
         for (int w = 0; w < 4096; w++) begin
            mem_a[w] <= 32'h5A00_0000 + 32'(w);
            mem_b[w] <= 32'h5A00_0000 + 32'(w);
         end
      end else begin
         for (int k = 0; k < 4; k++) begin
            if (a_ram_wstrb[k]) mem_a[a_ram_waddr][8*k +: 8] <= a_ram_wdata[8*k +: 8];
            if (b_ram_wstrb[k]) mem_b[b_ram_waddr][8*k +: 8] <= b_ram_wdata[8*k +: 8];
         end
      end
   end

   int n_vec  = 0;
   int n_miss = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
      end
   endtask

   task automatic send_a(input logic wr, input logic [13:0] addr, input logic [3:0] strb,
                         input logic [31:0] data, output logic fired);
      int waited;
      a_req_valid = 1'b1; a_req_write = wr; a_req_addr = addr;
      a_req_wstrb = strb; a_req_wdata = data;
      waited = 0;
      @(negedge clock);
      while (!a_req_ready && waited < 20) begin
         @(negedge clock);
         waited++;
      end
      fired = a_req_ready;
      @(posedge clock);
      #1;
      a_req_valid = 1'b0; a_req_write = 1'b0; a_req_wstrb = 4'h0;
   endtask

   task automatic wait_resp_a(output int lat, output logic w, output logic [31:0] d);
      lat = 0;
      do begin
         @(negedge clock);
         lat++;
      end while (!a_resp_valid && lat < 20);
      w = a_resp_write;
      d = a_resp_rdata;
      @(posedge clock);
      #1;
   endtask

   typedef struct {
      logic        wr;
      logic [13:0] addr;
      logic [3:0]  strb;
      logic [31:0] wdata;
      logic        exp_write;
      logic [31:0] exp_rdata;
   } vec_t;

   vec_t vt [11];

   initial begin
      #100000;
      $display("FAIL watchdog: bench did not reach its summary");
      $fatal(1);
   end

   initial begin
      logic        fired;
      logic        gw;
      logic [31:0] gd;
      int          lat, i, j, stale, first_fire, first_resp;
      int          fire_c [4];
      logic        op_w [4];
      logic [13:0] op_a [4];
      logic [31:0] op_d [4];
      logic        ex_w [3];
      logic [31:0] ex_d [3];

      vt[0]  = '{1'b1, 14'h0010, 4'hF, 32'hDEAD_BEEF, 1'b1, 32'h0000_0000};
      vt[1]  = '{1'b0, 14'h0010, 4'h0, 32'h0000_0000, 1'b0, 32'hDEAD_BEEF};
      vt[2]  = '{1'b1, 14'h0020, 4'hF, 32'hFFFF_FFFF, 1'b1, 32'h0000_0000};
      vt[3]  = '{1'b1, 14'h0020, 4'h3, 32'h1234_5678, 1'b1, 32'h0000_0000};
      vt[4]  = '{1'b0, 14'h0020, 4'h0, 32'h0000_0000, 1'b0, 32'hFFFF_5678};
      vt[5]  = '{1'b1, 14'h0024, 4'hC, 32'hAABB_CCDD, 1'b1, 32'h0000_0000};
      vt[6]  = '{1'b0, 14'h0024, 4'h0, 32'h0000_0000, 1'b0, 32'hAABB_0009};
      vt[7]  = '{1'b0, 14'h3FFC, 4'h0, 32'h0000_0000, 1'b0, 32'h5A00_0FFF};
      vt[8]  = '{1'b1, 14'h3FFC, 4'h9, 32'h1122_3344, 1'b1, 32'h0000_0000};
      vt[9]  = '{1'b0, 14'h3FFC, 4'h0, 32'h0000_0000, 1'b0, 32'h1100_0F44};
      vt[10] = '{1'b0, 14'h3FFE, 4'h0, 32'h0000_0000, 1'b0, 32'h1100_0F44};

      // Reset: a write is presented but must not reach the RAM.
      reset = 1'b0;
      a_req_valid = 1'b1; a_req_write = 1'b1; a_req_addr = 14'h0010;
      a_req_wstrb = 4'hF; a_req_wdata = 32'h0; a_resp_ready = 1'b1;
      b_req_valid = 1'b0; b_req_write = 1'b0; b_req_addr = 14'h0;
      b_req_wstrb = 4'h0; b_req_wdata = 32'h0; b_resp_ready = 1'b1;
      #12;
      chk("rst_req_ready", a_req_ready, 1'b0);
      chk("rst_resp_valid", a_resp_valid, 1'b0);
      chk("rst_resp_rdata", a_resp_rdata, 32'h0);
      chk("rst_ram_wstrb", a_ram_wstrb, 4'h0);
      chk("rst_b_resp_valid", b_resp_valid, 1'b0);
      @(posedge clock);
      @(posedge clock);
      #2;
      a_req_valid = 1'b0; a_req_write = 1'b0; a_req_wstrb = 4'h0;
      reset = 1'b1;
      @(negedge clock);
      chk("ready_after_reset", a_req_ready, 1'b1);
      @(posedge clock);
      #1;

      for (int v = 0; v < 11; v++) begin
         send_a(vt[v].wr, vt[v].addr, vt[v].strb, vt[v].wdata, fired);
         chk($sformatf("vec%0d_fire", v), fired, 1'b1);
         wait_resp_a(lat, gw, gd);
         chk($sformatf("vec%0d_latency", v), lat, 2);
         chk($sformatf("vec%0d_resp_write", v), gw, vt[v].exp_write);
         chk($sformatf("vec%0d_rdata", v), gd, vt[v].exp_rdata);
      end

      // A read right behind a write waits until the write has committed.
      a_resp_ready = 1'b0;
      send_a(1'b1, 14'h0050, 4'hF, 32'hCAFE_F00D, fired);
      chk("raw_wr_fire", fired, 1'b1);
      a_req_valid = 1'b1; a_req_write = 1'b0; a_req_addr = 14'h0050;
      @(negedge clock);
      chk("raw_rd_stall", a_req_ready, 1'b0);
      @(negedge clock);
      chk("raw_rd_go", a_req_ready, 1'b1);
      @(posedge clock);
      #1;
      a_req_valid = 1'b0;
      a_resp_ready = 1'b1;
      wait_resp_a(lat, gw, gd);
      chk("raw_first_is_write", gw, 1'b1);
      chk("raw_write_rdata", gd, 32'h0);
      wait_resp_a(lat, gw, gd);
      chk("raw_second_is_read", gw, 1'b0);
      chk("raw_read_rdata", gd, 32'hCAFE_F00D);

      // Six reads against a blocked response port: only four credits exist.
      a_resp_ready = 1'b0;
      i = 0;
      for (int c = 0; c < 12; c++) begin
         a_req_valid = (i < 6); a_req_write = 1'b0;
         a_req_addr = 14'h0100 + 14'(i * 4);
         @(negedge clock);
         if (a_req_valid && a_req_ready) i++;
         @(posedge clock);
         #1;
      end
      chk("bp_fired", i, 4);
      chk("bp_ready_low", a_req_ready, 1'b0);
      a_req_valid = 1'b0;
      a_resp_ready = 1'b1;
      for (int k = 0; k < 4; k++) begin
         wait_resp_a(lat, gw, gd);
         chk($sformatf("bp_drain%0d", k), gd, 32'h5A00_0040 + 32'(k));
      end
      @(negedge clock);
      chk("bp_empty", a_resp_valid, 1'b0);
      @(posedge clock);
      #1;

      // Full FIFO with pop and fire together, then a stream that wraps the pointers.
      a_resp_ready = 1'b0;
      i = 0; j = 0;
      for (int c = 0; c < 60 && j < 10; c++) begin
         a_resp_ready = (c >= 6);
         a_req_valid = (i < 10); a_req_write = 1'b0;
         a_req_addr = 14'h0200 + 14'(i * 4);
         @(negedge clock);
         if (c == 4) chk("full_stall", a_req_ready, 1'b0);
         if (c == 6) chk("full_pop_fire", a_req_ready, 1'b1);
         if (a_resp_valid && a_resp_ready) begin
            chk($sformatf("wrap_order%0d", j), a_resp_rdata, 32'h5A00_0080 + 32'(j));
            j++;
         end
         if (a_req_valid && a_req_ready) i++;
         @(posedge clock);
         #1;
      end
      a_req_valid = 1'b0;
      chk("wrap_fired", i, 10);
      chk("wrap_returned", j, 10);

      // READ_DELAY=3 instance: W,R,W back to back.
      op_w[0] = 1'b1; op_a[0] = 14'h0040; op_d[0] = 32'h0BAD_F00D;
      op_w[1] = 1'b0; op_a[1] = 14'h0040; op_d[1] = 32'h0;
      op_w[2] = 1'b1; op_a[2] = 14'h0044; op_d[2] = 32'h1212_1212;
      op_w[3] = 1'b0; op_a[3] = 14'h0;    op_d[3] = 32'h0;
      ex_w[0] = 1'b1; ex_d[0] = 32'h0;
      ex_w[1] = 1'b0; ex_d[1] = 32'h0BAD_F00D;
      ex_w[2] = 1'b1; ex_d[2] = 32'h0;
      b_resp_ready = 1'b1;
      i = 0; j = 0; first_resp = -1;
      for (int c = 0; c < 40 && j < 3; c++) begin
         b_req_valid = (i < 3); b_req_write = op_w[i]; b_req_addr = op_a[i];
         b_req_wdata = op_d[i]; b_req_wstrb = op_w[i] ? 4'hF : 4'h0;
         @(negedge clock);
         if (b_resp_valid) begin
            if (first_resp < 0) first_resp = c;
            chk($sformatf("mix%0d_write", j), b_resp_write, ex_w[j]);
            chk($sformatf("mix%0d_rdata", j), b_resp_rdata, ex_d[j]);
            j++;
         end
         if (b_req_valid && b_req_ready) begin
            fire_c[i] = c;
            i++;
         end
         @(posedge clock);
         #1;
      end
      b_req_valid = 1'b0; b_req_wstrb = 4'h0;
      first_fire = fire_c[0];
      chk("mix_count", j, 3);
      chk("mix_first_latency", first_resp - first_fire, 4);
      chk("mix_read_waits_commit", fire_c[1] - fire_c[0], 2);

      // Reset with two reads in flight: nothing may survive it.
      a_resp_ready = 1'b0;
      send_a(1'b0, 14'h0300, 4'h0, 32'h0, fired);
      send_a(1'b0, 14'h0304, 4'h0, 32'h0, fired);
      chk("inflight_resp_valid", a_resp_valid, 1'b1);
      a_req_valid = 1'b1; a_req_write = 1'b1; a_req_addr = 14'h0300; a_req_wstrb = 4'hF;
      #2;
      reset = 1'b0;
      #1;
      chk("pulse_resp_valid", a_resp_valid, 1'b0);
      chk("pulse_req_ready", a_req_ready, 1'b0);
      chk("pulse_ram_wstrb", a_ram_wstrb, 4'h0);
      @(negedge clock);
      chk("pulse_ram_wstrb_hold", a_ram_wstrb, 4'h0);
      chk("pulse_resp_write", a_resp_write, 1'b0);
      @(posedge clock);
      #2;
      a_req_valid = 1'b0; a_req_write = 1'b0; a_req_wstrb = 4'h0;
      reset = 1'b1;
      a_resp_ready = 1'b1;
      stale = 0;
      @(negedge clock);
      chk("release_ready", a_req_ready, 1'b1);
      for (int c = 0; c < 6; c++) begin
         if (a_resp_valid) stale++;
         @(negedge clock);
      end
      chk("no_stale_resp", stale, 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
